// File: rtl/thermal_pkg.sv
// thermal_pkg: shared types and helpers for the thermal frame pipeline.
// Holds the frame-stats FSM state encoding and the signed extreme-value helpers
// used to seed the running min/max for any pixel width.
package thermal_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SCAN      = 3'd1,
        DRAIN     = 3'd2,
        REPORT    = 3'd3,
        WAIT_NORM = 3'd4
    } t_stats_state;

    localparam int STATS_DATAW = 16;

    // Largest two's complement value representable in 'width' bits.
    function automatic logic signed [63:0] smax_of(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Smallest two's complement value representable in 'width' bits.
    function automatic logic signed [63:0] smin_of(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/frame_stats_scanner_minmax_accum.sv
// minmax_accum: running signed minimum/maximum over a stream of samples.
// 'clear' reseeds min with the largest value and max with the smallest value,
// so the first valid sample always replaces both.
module minmax_accum
    import thermal_pkg::*;
#(
    parameter int DATAW = STATS_DATAW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [DATAW-1:0] sample,
    output logic [DATAW-1:0] run_min,
    output logic [DATAW-1:0] run_max
);

    localparam logic signed [DATAW-1:0] MIN_SEED = DATAW'(smax_of(DATAW));
    localparam logic signed [DATAW-1:0] MAX_SEED = DATAW'(smin_of(DATAW));

    logic signed [DATAW-1:0] lo_r;
    logic signed [DATAW-1:0] hi_r;
    logic signed [DATAW-1:0] sample_s;

    assign sample_s = sample;
    assign run_min  = lo_r;
    assign run_max  = hi_r;

    // Reseed on clear, otherwise fold each valid sample into min and max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_r <= MIN_SEED;
            hi_r <= MAX_SEED;
        end else if (clear) begin
            lo_r <= MIN_SEED;
            hi_r <= MAX_SEED;
        end else if (sample_valid) begin
            if (sample_s < lo_r) lo_r <= sample_s;
            if (sample_s > hi_r) hi_r <= sample_s;
        end
    end

endmodule

// File: rtl/frame_stats_scanner.sv
// frame_stats_scanner: scans one raw thermal frame from RAM, finds its signed
// min and max, and hands min/range to the normaliser with a one-cycle start.
// Optional feature macro: FRAME_STATS_RANGE_CLAMP_EN raises the range floor
// from 1 to MIN_RANGE to limit noise gain on flat scenes.
// Read handshake: o_rd_valid high with o_rd_addr is a request the RAM always
// accepts; its data appears on i_rd_data exactly RD_LATENCY cycles later.
module frame_stats_scanner
    import thermal_pkg::*;
#(
    parameter  int DATAW      = STATS_DATAW,
    parameter  int MAX_ADDR   = 768,
    parameter  int RD_LATENCY = 1,
    parameter  int MIN_RANGE  = 16,
    localparam int ADDRW      = $clog2(MAX_ADDR)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_frame_ready,
    output logic             o_rd_valid,
    output logic [ADDRW-1:0] o_rd_addr,
    input  logic [DATAW-1:0] i_rd_data,
    output logic             o_start,
    output logic [DATAW-1:0] o_min,
    output logic [DATAW-1:0] o_range,
    input  logic             i_norm_done,
    output logic             o_busy
);

`ifdef FRAME_STATS_RANGE_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    localparam int                      DIFFW       = DATAW + 1;
    localparam logic [ADDRW-1:0]        ADDR_LAST   = ADDRW'(MAX_ADDR - 1);
    localparam logic signed [DIFFW-1:0] DIFF_SAT    = DIFFW'(smax_of(DATAW));
    // A floor of 1 keeps the normaliser divider away from zero; the clamp
    // option lifts that floor to MIN_RANGE.
    localparam logic [DATAW-1:0]        RANGE_FLOOR = CLAMP_EN ? DATAW'(MIN_RANGE) : DATAW'(1);

    typedef struct packed {
        t_stats_state          state;
        logic                  pending;  // frame arrived while busy
        logic [ADDRW-1:0]      addr;
        logic [RD_LATENCY-1:0] tag;      // in-flight read markers
        logic                  start;
        logic [DATAW-1:0]      min;
        logic [DATAW-1:0]      range;
    } t_regs;

    t_regs s_r;
    t_regs s_rin;

    logic                    acc_clear;
    logic                    sample_valid;
    logic [DATAW-1:0]        acc_min;
    logic [DATAW-1:0]        acc_max;
    logic signed [DIFFW-1:0] diff;
    logic [DATAW-1:0]        range_calc;

    assign sample_valid = s_r.tag[RD_LATENCY-1];

    minmax_accum #(
        .DATAW (DATAW)
    ) u_accum (
        .clk          (i_clk),
        .rst_n        (i_rst_n),
        .clear        (acc_clear),
        .sample_valid (sample_valid),
        .sample       (i_rd_data),
        .run_min      (acc_min),
        .run_max      (acc_max)
    );

    // Range from the running extremes: widen, saturate, then apply the floor.
    always_comb begin
        diff = DIFFW'($signed(acc_max)) - DIFFW'($signed(acc_min));
        if (diff > DIFF_SAT) begin
            range_calc = DATAW'(DIFF_SAT);
        end else begin
            range_calc = diff[DATAW-1:0];
        end
        if (range_calc < RANGE_FLOOR) begin
            range_calc = RANGE_FLOOR;
        end
    end

    // Next-state logic for the FSM, read tags and reported statistics.
    always_comb begin
        s_rin       = s_r;
        s_rin.start = 1'b0;
        acc_clear   = 1'b0;

        s_rin.tag[0] = (s_r.state == SCAN);
        for (int i = 1; i < RD_LATENCY; i++) begin
            s_rin.tag[i] = s_r.tag[i-1];
        end

        if (i_frame_ready && (s_r.state != IDLE)) begin
            s_rin.pending = 1'b1;
        end

        case (s_r.state)
            IDLE: begin
                if (i_frame_ready || s_r.pending) begin
                    s_rin.state   = SCAN;
                    s_rin.pending = 1'b0;
                    s_rin.addr    = '0;
                    acc_clear     = 1'b1;
                end
            end
            SCAN: begin
                if (s_r.addr == ADDR_LAST) begin
                    s_rin.state = DRAIN;
                    s_rin.addr  = '0;
                end else begin
                    s_rin.addr = s_r.addr + ADDRW'(1);
                end
            end
            DRAIN: begin
                // Leave once the last sample is being folded in this cycle.
                if (s_rin.tag == '0) begin
                    s_rin.state = REPORT;
                end
            end
            REPORT: begin
                s_rin.min   = acc_min;
                s_rin.range = range_calc;
                s_rin.start = 1'b1;
                s_rin.state = WAIT_NORM;
            end
            WAIT_NORM: begin
                if (i_norm_done) begin
                    s_rin.state = IDLE;
                end
            end
            default: begin
                s_rin.state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s_r <= '0;
        end else begin
            s_r <= s_rin;
        end
    end

    assign o_rd_valid = (s_r.state == SCAN);
    assign o_rd_addr  = s_r.addr;
    assign o_start    = s_r.start;
    assign o_min      = s_r.min;
    assign o_range    = s_r.range;
    assign o_busy     = (s_r.state != IDLE);

endmodule
